// File: rtl/pio_pwm_pkg.sv
// Shared constants and helpers for the PIO-driven PWM dimmer.
package pio_pwm_pkg;

    localparam int DUTY_W            = 8;
    localparam int PHASE_MAX         = 255;
    localparam int PRESCALE_W        = 16;
    localparam int DEFAULT_PRESCALE  = 195;
    localparam int DEFAULT_SLEW_STEP = 0;

    typedef logic [DUTY_W-1:0] duty_t;

    // Move cur toward tgt by at most step; step of zero means jump straight to tgt.
    // The gap is formed one bit wider so the comparison never wraps.
    function automatic duty_t slew_toward(input duty_t cur, input duty_t tgt, input duty_t step);
        logic [DUTY_W:0] gap;
        duty_t           next;
        next = tgt;
        gap  = '0;
        if (step != '0) begin
            if (tgt >= cur) begin
                gap = {1'b0, tgt} - {1'b0, cur};
                if (gap > {1'b0, step}) begin
                    next = cur + step;
                end
            end else begin
                gap = {1'b0, cur} - {1'b0, tgt};
                if (gap > {1'b0, step}) begin
                    next = cur - step;
                end
            end
        end
        return next;
    endfunction

endpackage

// File: rtl/pio_pwm_dimmer_tick_gen.sv
// Prescaler producing one phase-step tick every PRESCALE+1 clocks.
module pwm_tick_gen
    import pio_pwm_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE);

    logic [PRESCALE_W-1:0] count;

    // Count 0..PRESCALE while enabled; held at 0 while stopped so a restart begins a fresh period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Left ungated by enable so a boundary already reached in the stop cycle still lands.
    assign tick = (count == LAST);

endmodule

// File: rtl/pio_pwm_dimmer.sv
// PWM dimmer fed by the PIO level byte; duty changes only at period boundaries.
module pio_pwm_dimmer
    import pio_pwm_pkg::*;
#(
    parameter int PRESCALE  = DEFAULT_PRESCALE,
    parameter int SLEW_STEP = DEFAULT_SLEW_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DUTY_W-1:0] level,
    input  logic              enable,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty_cur,
    output logic              period_tick,
    output logic              at_target
);

    localparam duty_t PHASE_LAST = DUTY_W'(PHASE_MAX);
    localparam duty_t SLEW_V     = DUTY_W'(SLEW_STEP);

    logic  tick;
    logic  boundary;
    duty_t phase;
    duty_t target_q;

    pwm_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign boundary  = tick && (phase == PHASE_LAST);
    assign at_target = (duty_cur == target_q);

    // Track the software level every cycle, even while stopped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q <= '0;
        end else begin
            target_q <= level;
        end
    end

    // Phase advances once per tick and wraps naturally from 255 to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else if (!enable) begin
            phase <= '0;
        end else if (tick) begin
            phase <= phase + 1'b1;
        end
    end

    // Duty is only touched on the wrap edge so a running period is never reshaped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_cur <= '0;
        end else if (boundary) begin
            duty_cur <= slew_toward(duty_cur, target_q, SLEW_V);
        end
    end

    // Registered outputs keep the pin and the boundary pulse glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out     <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            pwm_out     <= enable && (phase < duty_cur);
            period_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_pio_pwm_dimmer.sv
// Bench for pio_pwm_dimmer: two instances (PRESCALE=1/no slew, PRESCALE=0/slew 16) share stimulus.
module tb_pio_pwm_dimmer;

    localparam int PS_A = 1;
    localparam int SL_A = 0;
    localparam int PS_B = 0;
    localparam int SL_B = 16;

    typedef struct {
        logic [7:0] level;
        logic [7:0] exp_duty;
        logic       exp_at;
    } vec_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] level  = 8'd0;

    logic       pwm_a, ptick_a, at_a;
    logic       pwm_b, ptick_b, at_b;
    logic [7:0] duty_a, duty_b;

    int checks   = 0;
    int failures = 0;
    bit model_on = 1'b0;

    // Reference model state: time within period, duty, registered target, registered outputs.
    int m_t[2];
    int m_duty[2];
    int m_target[2];
    int m_pwm[2];
    int m_ptick[2];

    pio_pwm_dimmer #(.PRESCALE(PS_A), .SLEW_STEP(SL_A)) dut_a (
        .clk(clk), .reset(reset), .level(level), .enable(enable),
        .pwm_out(pwm_a), .duty_cur(duty_a), .period_tick(ptick_a), .at_target(at_a)
    );

    pio_pwm_dimmer #(.PRESCALE(PS_B), .SLEW_STEP(SL_B)) dut_b (
        .clk(clk), .reset(reset), .level(level), .enable(enable),
        .pwm_out(pwm_b), .duty_cur(duty_b), .period_tick(ptick_b), .at_target(at_b)
    );

    always #5 clk = ~clk;

    function automatic int ps_of(input int i);
        return (i == 0) ? PS_A : PS_B;
    endfunction

    function automatic int sl_of(input int i);
        return (i == 0) ? SL_A : SL_B;
    endfunction

    function automatic int slew_model(input int cur, input int tgt, input int step);
        if (step == 0) return tgt;
        if (tgt > cur) return (tgt - cur > step) ? cur + step : tgt;
        return (cur - tgt > step) ? cur - step : tgt;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            if (failures <= 40)
                $display("[TB] FAIL %s actual=%0d required=%0d time=%0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: one clock counter per period, phase and boundary derived arithmetically.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_t[i] = 0; m_duty[i] = 0; m_target[i] = 0; m_pwm[i] = 0; m_ptick[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int per;
                int ph;
                bit bnd;
                per = 256 * (ps_of(i) + 1);
                ph  = (m_t[i] / (ps_of(i) + 1)) % 256;
                bnd = ((m_t[i] % per) == per - 1);
                m_pwm[i]   = (enable && (ph < m_duty[i])) ? 1 : 0;
                m_ptick[i] = bnd ? 1 : 0;
                if (bnd) m_duty[i] = slew_model(m_duty[i], m_target[i], sl_of(i));
                m_target[i] = int'(level);
                m_t[i] = enable ? (m_t[i] + 1) % per : 0;
            end
        end
    end

    // Continuous comparison of both instances against the model.
    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("pwm_a",   int'(pwm_a),   m_pwm[0]);
            checkOutput("duty_a",  int'(duty_a),  m_duty[0]);
            checkOutput("ptick_a", int'(ptick_a), m_ptick[0]);
            checkOutput("at_a",    int'(at_a),    (m_duty[0] == m_target[0]) ? 1 : 0);
            checkOutput("pwm_b",   int'(pwm_b),   m_pwm[1]);
            checkOutput("duty_b",  int'(duty_b),  m_duty[1]);
            checkOutput("ptick_b", int'(ptick_b), m_ptick[1]);
            checkOutput("at_b",    int'(at_b),    (m_duty[1] == m_target[1]) ? 1 : 0);
        end
    end

    task automatic wait_tick(input int which, input int maxc, output int n);
        logic got;
        n = 0;
        got = 1'b0;
        while (!got && n < maxc) begin
            @(negedge clk);
            n++;
            got = (which == 0) ? ptick_a : ptick_b;
        end
        if (!got) checkOutput((which == 0) ? "tick_a_timeout" : "tick_b_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int n;
        level = v.level;
        wait_tick(1, 300, n);
        checkOutput("tbl_duty_b", int'(duty_b), int'(v.exp_duty));
        checkOutput("tbl_at_b",   int'(at_b),   int'(v.exp_at));
    endtask

    // Sample one 512-clock period of instance A starting at its tick cycle.
    task automatic measure_a(input int chg_c, input logic [7:0] chg_level,
                             output int highs, output int rises, output int first);
        logic prev;
        highs = 0; rises = 0; first = -1; prev = 1'b0;
        for (int c = 0; c < 512; c++) begin
            if (c > 0) @(negedge clk);
            if (pwm_a) begin
                highs++;
                if (first < 0) first = c;
                if (!prev) rises++;
            end
            prev = pwm_a;
            if (c == chg_c) level = chg_level;
        end
    endtask

    vec_t tbl[8];

    initial begin
        int n, na, nb, highs, rises, first, cnt, exp_b;

        tbl[0] = '{8'd100, 8'd16,  1'b0};
        tbl[1] = '{8'd100, 8'd32,  1'b0};
        tbl[2] = '{8'd100, 8'd48,  1'b0};
        tbl[3] = '{8'd100, 8'd64,  1'b0};
        tbl[4] = '{8'd100, 8'd80,  1'b0};
        tbl[5] = '{8'd100, 8'd96,  1'b0};
        tbl[6] = '{8'd100, 8'd100, 1'b1};
        tbl[7] = '{8'd90,  8'd90,  1'b1};

        model_on = 1'b1;
        @(negedge clk);
        checkOutput("rst_pwm_a",   int'(pwm_a),   0);
        checkOutput("rst_duty_a",  int'(duty_a),  0);
        checkOutput("rst_ptick_a", int'(ptick_a), 0);
        checkOutput("rst_at_a",    int'(at_a),    1);

        #1 reset = 1'b0;
        enable = 1'b1;
        wait_tick(1, 300, n);
        checkOutput("first_period_b", n, 256);

        // Slew toward 100 then a small step back down.
        foreach (tbl[i]) applyStimulus(tbl[i]);

        // Instance A: direct jumps and pulse widths per period.
        level = 8'd64;
        wait_tick(0, 600, n);
        checkOutput("duty64_a", int'(duty_a), 64);
        measure_a(0, 8'd0, highs, rises, first);
        checkOutput("highs64_a", highs, 128);
        checkOutput("rises64_a", rises, 1);
        checkOutput("first64_a", first, 1);

        @(negedge clk);
        checkOutput("tick0_a", int'(ptick_a), 1);
        checkOutput("duty0_a", int'(duty_a), 0);
        checkOutput("at0_a",   int'(at_a),   1);
        measure_a(0, 8'd255, highs, rises, first);
        checkOutput("highs0_a", highs, 0);

        @(negedge clk);
        checkOutput("duty255_a", int'(duty_a), 255);
        checkOutput("at255_a",   int'(at_a),   1);
        measure_a(0, 8'd40, highs, rises, first);
        checkOutput("highs255_a", highs, 510);

        // Level changes mid-period: the running period keeps duty 40.
        @(negedge clk);
        checkOutput("duty40_a", int'(duty_a), 40);
        measure_a(200, 8'd200, highs, rises, first);
        checkOutput("highs40_a", highs, 80);
        checkOutput("rises40_a", rises, 1);

        @(negedge clk);
        checkOutput("duty200_a", int'(duty_a), 200);
        measure_a(0, 8'd128, highs, rises, first);
        checkOutput("highs200_a", highs, 400);

        // Stop at phase 30 with duty 128, then restart.
        @(negedge clk);
        checkOutput("duty128_a", int'(duty_a), 128);
        repeat (60) @(negedge clk);
        checkOutput("pwm_before_stop_a", int'(pwm_a), 1);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("pwm_stop_a", int'(pwm_a), 0);
        cnt = 0;
        repeat (600) begin
            @(negedge clk);
            if (ptick_a || ptick_b) cnt++;
        end
        checkOutput("ticks_stopped", cnt, 0);
        enable = 1'b1;
        wait_tick(0, 700, n);
        checkOutput("restart_period_a", n, 512);
        checkOutput("duty_kept_a", int'(duty_a), 128);

        // Instance B: stop exactly in the boundary cycle; update still lands.
        level = 8'd200;
        exp_b = slew_model(m_duty[1], 200, SL_B);
        repeat (255) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("stop_bnd_duty_b", int'(duty_b), exp_b);
        checkOutput("stop_bnd_pwm_b",  int'(pwm_b),  0);
        enable = 1'b1;

        // Asynchronous reset mid-period with duty 80.
        level = 8'd80;
        wait_tick(0, 700, n);
        checkOutput("duty80_a", int'(duty_a), 80);
        repeat (100) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_pwm_a",   int'(pwm_a),   0);
        checkOutput("async_duty_a",  int'(duty_a),  0);
        checkOutput("async_ptick_a", int'(ptick_a), 0);
        checkOutput("async_at_a",    int'(at_a),    1);
        checkOutput("async_duty_b",  int'(duty_b),  0);
        @(negedge clk);
        #1 reset = 1'b0;
        na = -1; nb = -1;
        for (int k = 1; k <= 600 && na < 0; k++) begin
            @(negedge clk);
            if (ptick_a && na < 0) na = k;
            if (ptick_b && nb < 0) nb = k;
        end
        checkOutput("post_rst_period_a", na, 512);
        checkOutput("post_rst_period_b", nb, 256);

        // Randomised traffic against the model.
        repeat (4000) begin
            @(negedge clk);
            if ($urandom_range(7, 0) == 0) level = 8'($urandom);
            if ($urandom_range(499, 0) == 0) enable = ~enable;
        end

        @(negedge clk);
        model_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
